led_ctrl: RTL and testbench
===========================

Name: led_ctrl

Overview:
- Consumer of the key front end's one-cycle press pulses: `key_led_reg[2:0]` and `key_mode_reg`.
- Holds a 3-bit LED enable mask and a 3-state display mode: static, blink, flow.
- Drives the board LEDs from a free-running prescaler tick.
- Sits directly downstream of the key edge detector, on the same clock.

Parameters:
- CNT_MAX, 25_000_000, tick period in clk cycles (0.5 s at 50 MHz). Legal range ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous and active-high (sampled on rising clk)
- key_led_reg  input  3  one-cycle press pulses; bit i toggles enable of LED i
- key_mode_reg  input  1  one-cycle press pulse; advances display mode
- led  output  3  LED drive, registered, 1 = on
- mode  output  2  current mode: 0 STATIC, 1 BLINK, 2 FLOW

Behaviour:
- Reset, when rst = 1 at a rising edge:
  - mode = 0, en = 000, cnt = 0, phase = 1, pos = 001, led = 000.
  - rst overrides every input pulse in that cycle.
- Inputs carry no internal edge detection. A level held high acts as one pulse per cycle: a held key_led bit toggles every cycle; a held key_mode advances mode every cycle.
- Prescaler:
  - cnt counts 0..CNT_MAX-1 and wraps to 0.
  - tick = 1 combinationally when cnt == CNT_MAX-1, giving one tick per CNT_MAX cycles.
  - A key_mode_reg pulse forces cnt to 0 at that edge.
- Enable mask:
  - On each edge where key_led_reg[i] = 1, en[i] inverts. This applies in all modes, and multiple bits in one cycle each toggle.
  - en is retained across mode changes.
- Mode FSM, advanced on a key_mode_reg pulse:
  - STATIC(0) → BLINK(1) → FLOW(2) → STATIC(0).
  - Encoding 3 is unreachable; if ever present, the next edge goes to STATIC.
  - On any mode change: phase = 1, pos = 001, cnt = 0.
- BLINK: phase inverts on each tick.
- FLOW: pos rotates left on each tick (001 → 010 → 100 → 001).
- Output decode, registered each edge from the post-edge-1 state values:
  - STATIC: led = en
  - BLINK: led = en & {3{phase}}
  - FLOW: led = pos (en ignored but preserved)
- Latency: a pulse sampled at edge k updates en / mode / phase / pos at edge k; led reflects it at edge k+1. mode output is the FSM register itself (visible after edge k).
- Simultaneous events:
  - key_mode_reg and tick in the same cycle: the mode change wins. phase/pos are reinitialised, not advanced, and cnt goes to 0.
  - key_mode_reg and key_led_reg in the same cycle: both apply.
- Reset mid-operation (any mode, any cnt): all state returns to reset values at that edge, and led = 000 from that edge.

Test Plan (CNT_MAX = 4):
1. Hold rst = 1 for 2 cycles, with key_led_reg = 111 and key_mode_reg = 1 also driven → led = 000, mode = 0, en unchanged at 000 after release.
2. STATIC: pulse key_led_reg = 001 at edge k → led = 001 at edge k+1. Pulse 001 again → led = 000. Pulse 101 → led = 101.
3. en = 101, pulse key_mode_reg → mode = 1. led = 101 for 4 cycles, then 000 for 4 cycles, repeating. Pulse key_led_reg = 100 mid-blink → on-phase shows 001.
4. From BLINK, pulse key_mode_reg → mode = 2, led = 001 for 4 cycles, then 010, 100, 001. Toggle en meanwhile → led unaffected. Return to STATIC → led = en.
5. In FLOW, pulse key_mode_reg together with key_led_reg = 010 in the same cycle as tick → mode = 0, led = en ^ 010 at next edge, cnt restarts at 0.
6. In FLOW with pos = 100, assert rst for one cycle → led = 000, mode = 0 at that edge. Subsequent key_mode_reg pulse → BLINK with en = 000, so led stays 000.

Source files
------------

// File: rtl/led_ctrl.sv
// led_ctrl -- LED enable mask and display-mode controller.
//
// Takes the one-cycle press pulses from the key edge detector and drives
// three board LEDs in one of three display modes:
//   STATIC (0) : LEDs show the enable mask directly
//   BLINK  (1) : enabled LEDs flash on/off, toggling on every prescaler tick
//   FLOW   (2) : a single lit LED walks 001 -> 010 -> 100, one step per tick
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   key_led_reg  [2:0] press pulses; bit i toggles the enable of LED i
//   key_mode_reg press pulse; advances STATIC -> BLINK -> FLOW -> STATIC
//   led          [2:0] registered LED drive, 1 = on
//   mode         [1:0] current display mode (the FSM register itself)
//
// Inputs are treated as levels: a bit held high acts on every cycle.

module led_ctrl #(
    parameter int CNT_MAX = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_led_reg,
    input  logic       key_mode_reg,
    output logic [2:0] led,
    output logic [1:0] mode
);

    localparam int              CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_FLOW   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    mode_t          mode_reg,  mode_next;
    logic [2:0]     en_reg,    en_next;
    logic [CW-1:0]  cnt_reg,   cnt_next;
    logic           phase_reg, phase_next;
    logic [2:0]     pos_reg,   pos_next;
    logic [2:0]     led_reg,   led_next;
    logic           tick;
    logic           mode_chg;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg  <= MODE_STATIC;
            en_reg    <= 3'b000;
            cnt_reg   <= '0;
            phase_reg <= 1'b1;
            pos_reg   <= 3'b001;
            led_reg   <= 3'b000;
        end else begin
            mode_reg  <= mode_next;
            en_reg    <= en_next;
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
            pos_reg   <= pos_next;
            led_reg   <= led_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: prescaler, enable mask, mode FSM, blink/flow
    // ------------------------------------------------------------------
    always_comb begin
        tick       = (cnt_reg == CNT_LAST);
        // The reserved encoding is treated like a mode press so it
        // self-recovers to STATIC on the very next edge.
        mode_chg   = key_mode_reg || (mode_reg == MODE_RSVD);

        mode_next  = mode_reg;
        en_next    = en_reg ^ key_led_reg;   // mask toggles in every mode
        cnt_next   = tick ? '0 : cnt_reg + 1'b1;
        phase_next = phase_reg;
        pos_next   = pos_reg;

        if (mode_chg) begin
            // A mode change outranks a coincident tick: animation state
            // is reinitialised rather than advanced, and the prescaler
            // restarts so the new mode begins with a full period.
            case (mode_reg)
                MODE_STATIC: mode_next = MODE_BLINK;
                MODE_BLINK:  mode_next = MODE_FLOW;
                default:     mode_next = MODE_STATIC;
            endcase
            phase_next = 1'b1;
            pos_next   = 3'b001;
            cnt_next   = '0;
        end else if (tick) begin
            case (mode_reg)
                MODE_BLINK: phase_next = ~phase_reg;
                MODE_FLOW:  pos_next   = {pos_reg[1:0], pos_reg[2]};
                default:    ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode, one bit per LED, from the current register values
    // (so LEDs trail a state change by one cycle).
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_led
            assign led_next[gi] =
                (mode_reg == MODE_STATIC) ? en_reg[gi] :
                (mode_reg == MODE_BLINK)  ? (en_reg[gi] & phase_reg) :
                (mode_reg == MODE_FLOW)   ? pos_reg[gi] :
                                            1'b0;
        end
    endgenerate

    assign led  = led_reg;
    assign mode = mode_reg;

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl -- directed testbench for led_ctrl with CNT_MAX = 4.
//
// Inputs change 1 ns after a rising edge and are sampled at the next one;
// outputs are checked 1 ns after the edge that produced them. Expected
// values are worked out by hand from the mode/tick timing.

module tb_led_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] key_led_reg;
    logic       key_mode_reg;
    logic [2:0] led;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    led_ctrl #(.CNT_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_led_reg  (key_led_reg),
        .key_mode_reg (key_mode_reg),
        .led          (led),
        .mode         (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, wait for the edge, then release them.
    task automatic cyc(input logic [2:0] kl, input logic km, input logic r);
        key_led_reg  = kl;
        key_mode_reg = km;
        rst          = r;
        @(posedge clk);
        #1;
        key_led_reg  = 3'b000;
        key_mode_reg = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic chk_led(input string tag, input logic [2:0] exp);
        n_checks++;
        assert (led === exp) else begin
            n_fail++;
            $error("FAIL %s: led got %b want %b", tag, led, exp);
        end
        $display("check %-12s led=%b exp=%b mode=%0d", tag, led, exp, mode);
    endtask

    task automatic chk_mode(input string tag, input logic [1:0] exp);
        n_checks++;
        assert (mode === exp) else begin
            n_fail++;
            $error("FAIL %s: mode got %0d want %0d", tag, mode, exp);
        end
        $display("check %-12s mode=%0d exp=%0d", tag, mode, exp);
    endtask

    initial begin
        logic [2:0] exp;
        rst          = 1'b1;
        key_led_reg  = 3'b111;
        key_mode_reg = 1'b1;

        // 1. Reset held two cycles with every key driven
        cyc(3'b111, 1'b1, 1'b1);
        chk_led ("rst0_led", 3'b000);
        chk_mode("rst0_mode", 2'd0);
        cyc(3'b111, 1'b1, 1'b1);
        chk_led ("rst1_led", 3'b000);
        chk_mode("rst1_mode", 2'd0);
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("rel_led", 3'b000);   // en stayed 000
        chk_mode("rel_mode", 2'd0);

        // 2. STATIC toggling, one-cycle output latency
        cyc(3'b001, 1'b0, 1'b0);
        chk_led ("st_lat", 3'b000);
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("st_on0", 3'b001);
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("st_off0", 3'b000);
        cyc(3'b101, 1'b0, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("st_101", 3'b101);

        // 3. BLINK: 4 on, 4 off with en = 101
        cyc(3'b000, 1'b1, 1'b0);
        chk_mode("bl_mode", 2'd1);
        chk_led ("bl_m0", 3'b101);
        for (int i = 1; i <= 9; i++) begin
            cyc(3'b000, 1'b0, 1'b0);
            exp = (i <= 4) ? 3'b101 : (i <= 8) ? 3'b000 : 3'b101;
            chk_led($sformatf("bl_%0d", i), exp);
        end
        cyc(3'b100, 1'b0, 1'b0);       // en -> 001 mid on-phase
        chk_led ("bl_tgl0", 3'b101);
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("bl_tgl1", 3'b001);
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("bl_tgl2", 3'b001);
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("bl_tgl3", 3'b000);

        // 4. FLOW: walking LED, en toggles ignored (en -> 110)
        cyc(3'b000, 1'b1, 1'b0);
        chk_mode("fl_mode", 2'd2);
        chk_led ("fl_f0", 3'b000);
        for (int i = 1; i <= 13; i++) begin
            cyc((i == 2) ? 3'b111 : 3'b000, 1'b0, 1'b0);
            exp = (i <= 4) ? 3'b001 : (i <= 8) ? 3'b010 :
                  (i <= 12) ? 3'b100 : 3'b001;
            chk_led($sformatf("fl_%0d", i), exp);
        end
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("fl_14", 3'b001);
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("fl_15", 3'b001);

        // 5. Mode + led pulse on the tick cycle: back to STATIC, en = 100
        cyc(3'b010, 1'b1, 1'b0);
        chk_mode("sim_mode", 2'd0);
        chk_led ("sim_led0", 3'b001);
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("sim_led1", 3'b100);

        // 6. Into FLOW again, reach pos = 100, then reset
        cyc(3'b000, 1'b1, 1'b0);
        chk_mode("re_bl", 2'd1);
        chk_led ("re_bl_led", 3'b100);
        cyc(3'b000, 1'b1, 1'b0);
        chk_mode("re_fl", 2'd2);
        chk_led ("re_fl_led", 3'b100);
        for (int i = 1; i <= 9; i++) begin
            cyc(3'b000, 1'b0, 1'b0);
            exp = (i <= 4) ? 3'b001 : (i <= 8) ? 3'b010 : 3'b100;
            chk_led($sformatf("re_fl_%0d", i), exp);
        end
        cyc(3'b000, 1'b0, 1'b1);
        chk_led ("mid_rst_led", 3'b000);
        chk_mode("mid_rst_mode", 2'd0);
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("post_rst", 3'b000);
        cyc(3'b000, 1'b1, 1'b0);
        chk_mode("post_bl", 2'd1);
        for (int i = 1; i <= 8; i++) begin
            cyc(3'b000, 1'b0, 1'b0);
            chk_led($sformatf("post_bl_%0d", i), 3'b000);
        end

        // Held levels act every cycle
        cyc(3'b000, 1'b1, 1'b0);
        chk_mode("hold_m1", 2'd2);
        cyc(3'b000, 1'b1, 1'b0);
        chk_mode("hold_m2", 2'd0);
        cyc(3'b011, 1'b0, 1'b0);
        chk_led ("hold_l0", 3'b000);
        cyc(3'b001, 1'b0, 1'b0);
        chk_led ("hold_l1", 3'b011);
        cyc(3'b000, 1'b0, 1'b0);
        chk_led ("hold_l2", 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
